down_cnt_timer: RTL
===================

// Module: down_cnt_timer
// PURPOSE
//  Loadable synchronous down-counter/timer; the count-down counterpart of the ripple up-counter (acc_rst).
//  Accepts a start value over a valid/ready load handshake and decrements once per enabled clock.
//  Flags terminal count and can auto-reload for periodic ticks.
//  Sits beside the up-counter as the timing source for lab-exam datapaths.
// PARAMETERS
//  WIDTH  4  counter/load width in bits; all count arithmetic is modulo 2^WIDTH, unsigned
// PORTS
//  clk         in   1      system clock; all state updates on rising edge
//  rst         in   1      asynchronous, active-low reset (rst=0 resets immediately, independent of clk)
//  clr         in   1      synchronous abort; returns to IDLE
//  en          in   1      count enable; decrement only when 1
//  auto_reload in   1      1: reload start value at terminal count; 0: stop at 0
//  load_valid  in   1      load request; load_val is valid
//  load_val    in   WIDTH  start value
//  load_ready  out  1      load can be accepted this cycle
//  q           out  WIDTH  current count (registered)
//  tc          out  1      terminal-count pulse, registered, 1 cycle
//  busy        out  1      1 while state==RUN
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, q=0, reload_reg=0, tc=0; busy=0; load_ready=1 once clr=0.
//  - States: IDLE (after reset/clr), RUN (counting), DONE (reached 0 with auto_reload=0).
//  - load_ready = (state!=RUN) && !clr. Combinational from state and clr only, never from load_valid.
//  - Load accepted on an edge where load_valid && load_ready: q<=load_val, reload_reg<=load_val.
//    - load_val!=0 -> RUN.
//    - load_val==0 -> DONE with tc=1 in the following cycle; empty load = immediate expiry.
//  - RUN, en=0: q, state and reload_reg hold; tc=0.
//  - RUN, en=1, q>1: q<=q-1, tc<=0.
//  - RUN, en=1, q==1 (terminal edge): tc<=1.
//    - auto_reload=1: q<=reload_reg, stay RUN.
//    - auto_reload=0: q<=0, go DONE.
//    - auto_reload is sampled only on this edge.
//  - auto_reload with reload_reg==1: tc=1 every enabled cycle; q stays 1.
//  - tc is high exactly one cycle per terminal event and is cleared on every other edge.
//  - No underflow: q never wraps from 0 to 2^WIDTH-1 in any state.
//  - DONE: q holds 0; load_ready=1; a new load restarts; no further tc without a new load.
//  - clr=1 (any state, sync): state=IDLE, q=0, tc=0; reload_reg keeps its value.
//    - Priority: clr > load > count.
//    - clr && load_valid -> load not accepted (load_ready=0).
//  - Loads while RUN are refused (load_ready=0); software must clr first to retarget.
//  - Async reset mid-count: outputs go to reset values immediately; count is not resumed on release.
//  - Latency: load edge -> first decrement on next enabled edge.
//    For start N and en held 1, tc goes high on the N-th edge after the load edge.
// STRUCTURE
//  - Shared include timer_defs.vh:
//    - state encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2
//    - default WIDTH constant
//  - Sub-module dff_ar #(W): W-bit register, async active-low reset to 0; holds q and reload_reg.
//  - Top level holds the next-state/next-count logic and the 2-bit state register.
//  - No other hierarchy.
// TESTING
//  1. rst=0 mid-count at q=5 -> q=0, tc=0, busy=0 immediately without a clk edge.
//     After release and clr=0, load_ready=1.
//  2. Load 4, en=1, auto_reload=0 -> q: 3,2,1,0 on successive edges.
//     tc=1 only on the edge q becomes 0; then DONE, busy=0, q stays 0 for 10 cycles.
//  3. Load 3, auto_reload=1, en=1 for 9 cycles.
//     q sequence 2,1,3,2,1,3,2,1,3; tc high on cycles 3, 6 and 9 only.
//  4. Load 5, toggle en 1,0,0,1,1 -> q 4,4,4,3,2.
//     load_valid=1 during RUN with load_val=9 -> load_ready=0, value ignored.
//  5. clr=1 with load_valid=1, load_val=7 in IDLE -> not accepted, q=0.
//     Next cycle clr=0 -> accepted, q=7, busy=1.
//  6. Load 0 -> DONE, tc=1 for exactly one cycle, q=0.
//     WIDTH=4, load 15 -> 15 decrements to 0, no wrap.

Source files
------------

// File: rtl/down_cnt_timer_pkg.sv
// ============================================================================
// Module   : down_cnt_timer_pkg
// Purpose  : Shared state encodings and default width for the down-count timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package down_cnt_timer_pkg;

    localparam int c_default_width = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/down_cnt_timer_dff_ar.sv
// ============================================================================
// Module   : dff_ar
// Purpose  : W-bit register with asynchronous active-low reset to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dff_ar #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_q <= '0;
        end else begin
            o_q <= i_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/down_cnt_timer.sv
// ============================================================================
// Module   : down_cnt_timer
// Purpose  : Loadable down-counter/timer with terminal-count pulse and
//            optional auto-reload; rst is asynchronous and active-low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module down_cnt_timer
    import down_cnt_timer_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             auto_reload,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_val,
    output logic             load_ready,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_tc;
    logic             w_tc_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             w_load_acc;

    assign load_ready = (r_state != S_RUN) && !clr;
    assign w_load_acc = load_valid && load_ready;

    always_comb begin
        w_state_nxt  = r_state;
        w_q_nxt      = r_q;
        w_reload_nxt = r_reload;
        w_tc_nxt     = 1'b0;
        if (clr) begin
            w_state_nxt = S_IDLE;
            w_q_nxt     = '0;
        end else if (w_load_acc) begin
            w_q_nxt      = load_val;
            w_reload_nxt = load_val;
            // An empty load expires at once: straight to DONE with its tc pulse.
            if (load_val != '0) begin
                w_state_nxt = S_RUN;
            end else begin
                w_state_nxt = S_DONE;
                w_tc_nxt    = 1'b1;
            end
        end else if ((r_state == S_RUN) && en) begin
            if (r_q == WIDTH'(1)) begin
                w_tc_nxt = 1'b1;
                if (auto_reload) begin
                    w_q_nxt = r_reload;
                end else begin
                    w_q_nxt     = '0;
                    w_state_nxt = S_DONE;
                end
            end else if (r_q != '0) begin
                w_q_nxt = r_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_tc    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tc    <= w_tc_nxt;
        end
    end

    dff_ar #(.W(WIDTH)) u_q_reg (
        .clk (clk),
        .rst (rst),
        .i_d (w_q_nxt),
        .o_q (r_q)
    );

    dff_ar #(.W(WIDTH)) u_reload_reg (
        .clk (clk),
        .rst (rst),
        .i_d (w_reload_nxt),
        .o_q (r_reload)
    );

    assign q    = r_q;
    assign tc   = r_tc;
    assign busy = (r_state == S_RUN);

endmodule

`default_nettype wire
